// File: rtl/timer_pkg.sv
// Shared FSM state encoding and button index constants for timer_ctrl.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_MIN = 3'd1,
    SET_SEC = 3'd2,
    RUN     = 3'd3,
    PAUSE   = 3'd4,
    ALARM   = 3'd5
  } state_t;

  localparam int NUM_BTNS  = 5;
  localparam int BTN_CLR   = 0;
  localparam int BTN_START = 1;
  localparam int BTN_MODE  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 4;

endpackage

// File: rtl/btn_sync.sv
// Per-button synchronizer + registered rising-edge press pulse.
// Optional hold auto-repeat when TIMER_CTRL_AUTOREPEAT_EN is defined.
module btn_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync;
  logic lvl, prev, rise, rep;

  assign lvl  = sync[SYNC_STAGES-1];
  assign rise = lvl & ~prev;

  if (SYNC_STAGES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_cfg_err
    $error("btn_sync: illegal parameter values");
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      prev  <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], raw};
      prev  <= lvl;
      press <= rise | rep;
    end
  end

`ifdef TIMER_CTRL_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt;
  logic          rep_phase;

  // The press cycle counts as hold cycle 1, so a hold of N cycles sees a
  // repeat exactly on its last cycle when N hits the delay/period grid.
  assign rep = lvl & prev &
               (rcnt == (rep_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else if (!lvl) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else if (rise) begin
      rcnt      <= RW'(1);
      rep_phase <= 1'b0;
    end else if (rep) begin
      rcnt      <= '0;
      rep_phase <= 1'b1;
    end else begin
      rcnt      <= rcnt + RW'(1);
    end
  end
`else
  assign rep = 1'b0;
`endif

endmodule

// File: rtl/timer_ctrl.sv
// Countdown-timer control FSM: button handling, set/run/pause/alarm sequencing.
// Define TIMER_CTRL_AUTOREPEAT_EN to enable hold auto-repeat on the buttons.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int ALARM_CYCLES  = 10000,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clr,
  input  logic [6:0] t_min,
  input  logic [6:0] t_sec,
  input  logic [9:0] t_msec,
  input  logic       end_sig,
  output logic       enable,
  output logic       zero,
  output logic       im,
  output logic       dm,
  output logic       is,
  output logic       ds,
  output logic [2:0] state,
  output logic       sel_min,
  output logic       sel_sec,
  output logic       buzzer
);

  localparam int AW = $clog2(ALARM_CYCLES + 1);

  logic [NUM_BTNS-1:0] raw, ev;
  state_t              st, nxt;
  logic [AW-1:0]       acnt;
  logic [3:0]          pls_n;  // {im, dm, is, ds}
  logic                zero_n, nz, timeout;

  assign raw[BTN_CLR]   = btn_clr;
  assign raw[BTN_START] = btn_start;
  assign raw[BTN_MODE]  = btn_mode;
  assign raw[BTN_UP]    = btn_up;
  assign raw[BTN_DOWN]  = btn_down;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_sync #(
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .press(ev[i])
    );
  end

  assign nz      = |{t_min, t_sec, t_msec};
  assign timeout = (acnt >= AW'(ALARM_CYCLES - 1));
  assign state   = st;

  // Priority chain: only the highest-priority press event is acted on.
  always_comb begin
    nxt    = st;
    zero_n = 1'b0;
    pls_n  = 4'b0000;
    if (ev[BTN_CLR]) begin
      nxt    = IDLE;
      zero_n = 1'b1;
    end else begin
      case (st)
        IDLE, SET_MIN, SET_SEC: begin
          if (ev[BTN_START]) begin
            if (nz) nxt = RUN;
          end else if (ev[BTN_MODE]) begin
            nxt = (st == IDLE) ? SET_MIN : (st == SET_MIN) ? SET_SEC : IDLE;
          end else if (ev[BTN_UP]) begin
            pls_n = (st == SET_MIN) ? 4'b1000 : (st == SET_SEC) ? 4'b0010 : 4'b0000;
          end else if (ev[BTN_DOWN]) begin
            pls_n = (st == SET_MIN) ? 4'b0100 : (st == SET_SEC) ? 4'b0001 : 4'b0000;
          end
        end
        RUN: begin
          if (ev[BTN_START]) nxt = PAUSE;
          else if (end_sig)  nxt = ALARM;
        end
        PAUSE:   if (ev[BTN_START] && nz) nxt = RUN;
        ALARM:   if (|ev || timeout) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      acnt    <= '0;
      enable  <= 1'b0;
      zero    <= 1'b0;
      im      <= 1'b0;
      dm      <= 1'b0;
      is      <= 1'b0;
      ds      <= 1'b0;
      sel_min <= 1'b0;
      sel_sec <= 1'b0;
      buzzer  <= 1'b0;
    end else begin
      st               <= nxt;
      enable           <= (nxt == RUN);
      sel_min          <= (nxt == SET_MIN);
      sel_sec          <= (nxt == SET_SEC);
      buzzer           <= (nxt == ALARM);
      zero             <= zero_n;
      {im, dm, is, ds} <= pls_n;
      if (st == ALARM && nxt == ALARM)
        acnt <= (acnt == AW'(ALARM_CYCLES)) ? acnt : acnt + AW'(1);
      else
        acnt <= '0;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl (default parameters).
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start, btn_mode, btn_up, btn_down, btn_clr;
  logic [6:0] t_min, t_sec;
  logic [9:0] t_msec;
  logic       end_sig;
  logic       enable, zero, im, dm, is, ds, sel_min, sel_sec, buzzer;
  logic [2:0] state;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, im_cyc = 0;
  int n_im = 0, n_dm = 0, n_is = 0, n_ds = 0, n_zero = 0, n_en = 0, n_buzz = 0, n_viol = 0;

  timer_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .btn_clr(btn_clr),
    .t_min(t_min), .t_sec(t_sec), .t_msec(t_msec), .end_sig(end_sig),
    .enable(enable), .zero(zero), .im(im), .dm(dm), .is(is), .ds(ds),
    .state(state), .sel_min(sel_min), .sel_sec(sel_sec), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (im) begin n_im <= n_im + 1; im_cyc <= cyc; end
    if (dm)     n_dm   <= n_dm + 1;
    if (is)     n_is   <= n_is + 1;
    if (ds)     n_ds   <= n_ds + 1;
    if (zero)   n_zero <= n_zero + 1;
    if (enable) n_en   <= n_en + 1;
    if (buzzer) n_buzz <= n_buzz + 1;
    if ((32'(im) + 32'(dm) + 32'(is) + 32'(ds)) > 1 ||
        ((im | dm | is | ds | zero) && enable))
      n_viol <= n_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_clr   = v;
      1: btn_start = v;
      2: btn_mode  = v;
      3: btn_up    = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic push(input int b, input int hold);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
    wait_n(8);
  endtask

  localparam int CLR = 0, START = 1, MODE = 2, UP = 3, DOWN = 4;

  initial begin
    int b, t0, k;
    rst = 1'b0;
    {btn_start, btn_mode, btn_up, btn_down, btn_clr} = '0;
    t_min = '0; t_sec = '0; t_msec = '0; end_sig = 1'b0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_buzzer", 32'(buzzer), 0);
    @(negedge clk) rst = 1'b1;
    wait_n(3);

    // mode into SET_MIN, then a single up press
    push(MODE, 3);
    chk("mode_setmin", 32'(state), 1);
    chk("sel_min", 32'(sel_min), 1);
    b = n_im;
    @(negedge clk);
    t0 = cyc;
    btn_up = 1'b1;
    wait_n(3);
    btn_up = 1'b0;
    wait_n(8);
    chk("im_once", 32'(n_im - b), 1);
    chk("im_latency", 32'(im_cyc - t0), 4);
    b = n_dm;
    push(DOWN, 2);
    chk("dm_once", 32'(n_dm - b), 1);
    push(MODE, 2);
    chk("mode_setsec", 32'(state), 2);
    chk("sel_sec", 32'(sel_sec), 1);
    chk("sel_min_off", 32'(sel_min), 0);
    push(MODE, 2);
    chk("mode_idle", 32'(state), 0);
    b = n_im;
    push(UP, 2);
    chk("up_idle_ignored", 32'(n_im - b), 0);

    // start with zero time stays put
    b = n_en;
    push(START, 2);
    chk("start_zero_state", 32'(state), 0);
    chk("start_zero_en", 32'(n_en - b), 0);

    // run / pause / clear
    t_min = 7'd1;
    push(START, 2);
    chk("run_state", 32'(state), 3);
    chk("run_enable", 32'(enable), 1);
    push(START, 2);
    chk("pause_state", 32'(state), 4);
    chk("pause_enable", 32'(enable), 0);
    b = n_zero;
    push(CLR, 2);
    chk("clr_zero_pulse", 32'(n_zero - b), 1);
    chk("clr_state", 32'(state), 0);

    // alarm full timeout
    push(START, 2);
    chk("run2_state", 32'(state), 3);
    b = n_buzz;
    @(negedge clk) end_sig = 1'b1;
    @(negedge clk) end_sig = 1'b0;
    chk("alarm_state", 32'(state), 5);
    chk("alarm_enable", 32'(enable), 0);
    k = 0;
    while (state != 3'd0 && k < 12000) begin
      @(negedge clk);
      k++;
    end
    chk("alarm_bounded", 32'(k < 12000), 1);
    wait_n(2);
    chk("alarm_len", 32'(n_buzz - b), 10000);
    chk("alarm_exit_buzzer", 32'(buzzer), 0);

    // alarm cut short by a press
    push(START, 2);
    b = n_buzz;
    @(negedge clk) end_sig = 1'b1;
    @(negedge clk) end_sig = 1'b0;
    wait_n(48);
    push(UP, 3);
    chk("alarm_early_state", 32'(state), 0);
    chk("alarm_early_buzzer", 32'(buzzer), 0);
    chk("alarm_early_len", 32'((n_buzz - b) < 100), 1);

    // clr and start together while running
    push(START, 2);
    chk("run3_state", 32'(state), 3);
    b = n_zero;
    @(negedge clk);
    btn_clr = 1'b1; btn_start = 1'b1;
    wait_n(3);
    btn_clr = 1'b0; btn_start = 1'b0;
    wait_n(8);
    chk("clr_start_zero", 32'(n_zero - b), 1);
    chk("clr_start_state", 32'(state), 0);
    b = n_en;
    wait_n(20);
    chk("clr_start_no_en", 32'(n_en - b), 0);

    // reset mid-run drops enable at once, no zero pulse
    push(START, 2);
    b = n_zero;
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_run_enable", 32'(enable), 0);
    chk("rst_run_state", 32'(state), 0);
    @(negedge clk) rst = 1'b1;
    wait_n(3);
    chk("rst_run_no_zero", 32'(n_zero - b), 0);

    // hold up for 800 cycles in SET_SEC
    push(MODE, 2);
    push(MODE, 2);
    chk("setsec_state", 32'(state), 2);
    b = n_is;
    push(UP, 800);
    wait_n(12);
`ifdef TIMER_CTRL_AUTOREPEAT_EN
    chk("hold_is_count", 32'(n_is - b), 5);
`else
    chk("hold_is_count", 32'(n_is - b), 1);
`endif
    chk("pulse_rules", 32'(n_viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
